dlx_decode_stage: RTL and testbench
===================================

Name: dlx_decode_stage

Overview:
Registered DLX instruction-decode stage, the successor to the combinational control-signal decoder. It accepts instructions from fetch under a valid/ready handshake and decodes them into a control bundle. The bundle is held in the ID/EX pipeline register. A load-use scoreboard inserts bubbles, and the stage supports branch flush and downstream backpressure.

Parameters:
- REG_AW, 5, register-address width; the link register is all-ones (R31 at the default).
- LOAD_LAT, 1, load-to-use bubbles required (1..4); scoreboard depth.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch instruction valid
- in_ready  out  1  stage accepts in_instr this cycle
- in_instr  in  32  DLX instruction word
- flush  in  1  kill ID/EX contents and current input (branch taken in EX)
- out_valid  out  1  ID/EX register holds a live instruction
- out_ready  in  1  EX accepts the bundle
- out_rs1, out_rs2, out_rd  out  REG_AW each  source and destination registers
- out_imm  out  16  instr[15:0]
- out_value  out  26  instr[25:0], the jump offset
- out_alu_op  out  6  ALU function code
- out_ctrl  out  16  {reg_dst, alu_src, mem_wr, w_src, reg_wr, data_size[1:0], mem_sign, load_high, link, beqz, bnez, jump, jump_reg, 2'b00}

Behaviour:
- Reset:
  - out_valid = 0; all out_* data = 0; scoreboard cleared.
  - in_ready follows the equation below, so it is 1 immediately after reset.
- Handshake:
  - adv = ~out_valid | out_ready
  - in_ready = adv & ~hazard
  - Accept when in_valid & in_ready; the decoded bundle is registered next cycle (latency 1).
  - If adv & (hazard | ~in_valid), a bubble is loaded: out_valid = 0.
  - If ~adv, every output holds stable.
- Decode (opcode = instr[31:26]):
  - alu_src = |opcode[5:3]; mem_wr = (opcode[5:3] == 101); w_src = (opcode[5:3] == 100).
  - reg_dst = (opcode[5:1] == 0); data_size = opcode[1:0]; mem_sign = 0 only for opcode 1001xx.
  - Store 101xxx: reg_wr = 0, alu_op ADD.
  - Load 100xxx: reg_wr = 1, alu_op ADD.
  - LHI 001111: load_high = 1, alu_op ADD.
  - beqz 000100 / bnez 000101: reg_wr = 0.
  - J 000010: jump = 1, reg_wr = 0.
  - JAL 000011: jump = 1, link = 1, reg_wr = 1.
  - JR 010010: jump = 1, jump_reg = 1, reg_wr = 0.
  - JALR 010011: jump = 1, jump_reg = 1, link = 1, reg_wr = 1.
  - Link instructions force out_rd = all-ones, alu_op ADD.
  - NOP (0x00000015): reg_wr = 0.
  - R-type (opcode 0): out_alu_op = funct (instr[5:0]); out_rd = instr[15:11].
  - I-type ALU ops: out_rd = instr[20:16], with alu_op mapped as follows:
    - 0010xx / 0011xx -> 1000xx / 1001xx
    - 0110xx / 0111xx -> 1010xx / 1011xx
    - 0101xx -> 0001xx
  - Any other opcode: alu_op = 0 and reg_wr = 1 (legacy behaviour).
- Scoreboard:
  - LOAD_LAT-entry shift register of {v, rd}; shifts only when adv.
  - Entry 0 receives {1, rd} when an accepted instruction is a load, else {0, x}.
- Hazard:
  - hazard = in_valid and any valid entry whose rd != 0 matches rs1.
  - It also matches rs2 when the instruction reads rs2: R-type or store.
- Flush:
  - On the next edge out_valid = 0, entry 0 is cleared, and in_instr is consumed and discarded (in_ready = 1, no decode).
  - Older scoreboard entries are retained.
  - Flush overrides hazard and backpressure.

Optional Feature:
DLX_DECODE_PERF_EN.
- Defined:
  - Adds output stall_cnt (32) counting cycles where in_valid & adv & hazard.
  - Adds output bubble_cnt (32) counting bubbles loaded for any reason.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: neither port nor any counter logic exists.

Test Plan:
- Reset, then add r3,r1,r2 (0x00221820) with out_ready = 1 -> one cycle later: out_valid = 1, rd = 3, alu_op = 0x20, reg_dst = 1, reg_wr = 1.
- lw r5,0(r1), then add r6,r5,r2, LOAD_LAT = 1 -> in_ready = 0 for one cycle, one bubble, then the add issues; with rs = r0 loads, no stall.
- out_ready held 0 for 3 cycles with a bundle valid -> outputs stable, in_ready = 0, scoreboard frozen.
- jal 0x40 -> rd = 31, link = 1, jump = 1, reg_wr = 1; jr r31 -> jump_reg = 1, reg_wr = 0; NOP 0x00000015 -> reg_wr = 0.
- flush asserted while a load sits in ID/EX and a dependent instruction is pending -> out_valid = 0 next cycle, no hazard stall afterwards.
- With DLX_DECODE_PERF_EN: two load-use stalls -> stall_cnt = 2, bubble_cnt >= 2; rst_n asserted mid-run -> outputs and counters reset immediately.

Source files
------------

// File: rtl/dlx_decode_stage_if.sv
// -----------------------------------------------------------------------------
// dlx_decode_stage_if
// Bundles the fetch-side handshake, the branch flush and the ID/EX bundle of
// the DLX decode stage.
//   master : the surroundings (fetch + EX). Drives in_valid, in_instr, flush
//            and out_ready. Observes in_ready and the out_* bundle.
//   slave  : the decode stage itself.
// Parameter REG_AW is the register-address width. It must match the stage.
// -----------------------------------------------------------------------------
interface dlx_decode_stage_if #(
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [REG_AW-1:0] out_rs1;
  logic [REG_AW-1:0] out_rs2;
  logic [REG_AW-1:0] out_rd;
  logic [15:0]       out_imm;
  logic [25:0]       out_value;
  logic [5:0]        out_alu_op;
  logic [15:0]       out_ctrl;

  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_rs1, out_rs2, out_rd,
           out_imm, out_value, out_alu_op, out_ctrl
  );

  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, out_rs1, out_rs2, out_rd,
           out_imm, out_value, out_alu_op, out_ctrl
  );
endinterface

// File: rtl/dlx_decode_stage.sv
// -----------------------------------------------------------------------------
// dlx_decode_stage
// This is a registered DLX instruction-decode stage. It accepts an instruction
// from fetch under a valid/ready handshake. The stage decodes the instruction
// into a control bundle and holds that bundle in the ID/EX register. The
// latency is 1 cycle. A load-use scoreboard inserts bubbles. The stage
// supports branch flush and backpressure from EX.
//
// Ports
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   bus        : dlx_decode_stage_if.slave. The signals are:
//                - in_valid/in_ready/in_instr
//                - flush
//                - out_valid/out_ready
//                - out_rs1/out_rs2/out_rd
//                - out_imm, out_value, out_alu_op
//                - out_ctrl, packed as {reg_dst, alu_src, mem_wr, w_src,
//                  reg_wr, data_size[1:0], mem_sign, load_high, link, beqz,
//                  bnez, jump, jump_reg, 2'b00}
//   stall_cnt  : (DLX_DECODE_PERF_EN only) counts the cycles where a valid
//                instruction is held back by a load-use hazard. Saturates.
//   bubble_cnt : (DLX_DECODE_PERF_EN only) counts the bubbles loaded into
//                ID/EX for any reason. Saturates.
//
// Parameters
//   REG_AW   : register-address width. The link register is all-ones.
//   LOAD_LAT : number of load-to-use bubbles (1..4). This is also the
//              scoreboard depth.
//
// Optional feature macro: DLX_DECODE_PERF_EN (performance counters).
// -----------------------------------------------------------------------------
module dlx_decode_stage #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  dlx_decode_stage_if.slave   bus
`ifdef DLX_DECODE_PERF_EN
  ,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         bubble_cnt
`endif
);

  localparam logic [5:0] ALU_ADD = 6'h20;

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // ---------------------------------------------------------------------------
  logic [5:0]        opcode;
  logic              is_rtype, is_load, is_store, is_lhi, is_nop;
  logic              is_j, is_jal, is_jr, is_jalr, is_beqz, is_bnez;
  logic              dec_link, dec_jump, dec_jump_reg, dec_reg_wr;
  logic              dec_reg_dst, dec_alu_src, dec_mem_wr, dec_w_src, dec_mem_sign;
  logic              reads_rs2;
  logic [5:0]        dec_alu_op;
  logic [REG_AW-1:0] dec_rs1, dec_rs2, dec_rd;
  logic [15:0]       dec_ctrl;

  assign opcode = bus.in_instr[31:26];

  always_comb begin
    is_rtype = (opcode == 6'b000000);
    is_load  = (opcode[5:3] == 3'b100);
    is_store = (opcode[5:3] == 3'b101);
    is_lhi   = (opcode == 6'b001111);
    is_j     = (opcode == 6'b000010);
    is_jal   = (opcode == 6'b000011);
    is_jr    = (opcode == 6'b010010);
    is_jalr  = (opcode == 6'b010011);
    is_beqz  = (opcode == 6'b000100);
    is_bnez  = (opcode == 6'b000101);
    is_nop   = (bus.in_instr == 32'h0000_0015);

    dec_link     = is_jal | is_jalr;
    dec_jump     = is_j | is_jal | is_jr | is_jalr;
    dec_jump_reg = is_jr | is_jalr;
    // Unlisted opcodes keep the legacy reg_wr = 1.
    dec_reg_wr   = ~(is_store | is_beqz | is_bnez | is_j | is_jr | is_nop);

    dec_alu_src  = |opcode[5:3];
    dec_mem_wr   = is_store;
    dec_w_src    = is_load;
    dec_reg_dst  = (opcode[5:1] == 5'b00000);
    dec_mem_sign = ~(opcode[5:2] == 4'b1001);   // unsigned loads lbu/lhu

    // The I-type ALU opcodes reuse the low opcode bits as the low funct bits.
    dec_alu_op = 6'h00;
    if (is_rtype)
      dec_alu_op = bus.in_instr[5:0];
    else if (is_load | is_store | is_lhi | dec_link)
      dec_alu_op = ALU_ADD;
    else if (opcode[5:3] == 3'b001)
      dec_alu_op = {3'b100, opcode[2:0]};
    else if (opcode[5:3] == 3'b011)
      dec_alu_op = {3'b101, opcode[2:0]};
    else if (opcode[5:2] == 4'b0101)
      dec_alu_op = {4'b0001, opcode[1:0]};

    dec_rs1 = REG_AW'(bus.in_instr[25:21]);
    dec_rs2 = REG_AW'(bus.in_instr[20:16]);
    if (dec_link)
      dec_rd = '1;
    else if (is_rtype)
      dec_rd = REG_AW'(bus.in_instr[15:11]);
    else
      dec_rd = REG_AW'(bus.in_instr[20:16]);

    reads_rs2 = is_rtype | is_store;

    dec_ctrl = {dec_reg_dst, dec_alu_src, dec_mem_wr, dec_w_src, dec_reg_wr,
                opcode[1:0], dec_mem_sign, is_lhi, dec_link, is_beqz, is_bnez,
                dec_jump, dec_jump_reg, 2'b00};
  end

  // ---------------------------------------------------------------------------
  // Load-use scoreboard: a shift register of {valid, rd} that advances with
  // ID/EX. Entry 0 belongs to the instruction that currently sits in ID/EX.
  // ---------------------------------------------------------------------------
  logic              sb_v_reg  [LOAD_LAT];
  logic [REG_AW-1:0] sb_rd_reg [LOAD_LAT];
  logic [LOAD_LAT-1:0] sb_match;
  logic              hazard, adv, take;
  logic              out_valid_reg;

  assign adv = ~out_valid_reg | bus.out_ready;

  generate
    for (genvar gi = 0; gi < LOAD_LAT; gi++) begin : g_sb
      assign sb_match[gi] = sb_v_reg[gi] && (sb_rd_reg[gi] != '0) &&
                            ((sb_rd_reg[gi] == dec_rs1) ||
                             (reads_rs2 && (sb_rd_reg[gi] == dec_rs2)));

      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            sb_v_reg[gi]  <= 1'b0;
            sb_rd_reg[gi] <= '0;
          end else if (bus.flush) begin
            // Only the flushed ID/EX instruction is removed. Older loads are
            // still in flight.
            sb_v_reg[gi]  <= 1'b0;
          end else if (adv) begin
            sb_v_reg[gi]  <= take & is_load;
            sb_rd_reg[gi] <= dec_rd;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            sb_v_reg[gi]  <= 1'b0;
            sb_rd_reg[gi] <= '0;
          end else if (!bus.flush && adv) begin
            sb_v_reg[gi]  <= sb_v_reg[gi-1];
            sb_rd_reg[gi] <= sb_rd_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign hazard = bus.in_valid & (|sb_match);
  // During a flush the input is swallowed, so ready is forced high.
  assign bus.in_ready = bus.flush | (adv & ~hazard);
  assign take = ~bus.flush & bus.in_valid & adv & ~hazard;

  // ---------------------------------------------------------------------------
  // ID/EX pipeline register
  // ---------------------------------------------------------------------------
  logic [REG_AW-1:0] out_rs1_reg, out_rs2_reg, out_rd_reg;
  logic [15:0]       out_imm_reg, out_ctrl_reg;
  logic [25:0]       out_value_reg;
  logic [5:0]        out_alu_op_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg  <= 1'b0;
      out_rs1_reg    <= '0;
      out_rs2_reg    <= '0;
      out_rd_reg     <= '0;
      out_imm_reg    <= '0;
      out_value_reg  <= '0;
      out_alu_op_reg <= '0;
      out_ctrl_reg   <= '0;
    end else if (bus.flush) begin
      out_valid_reg  <= 1'b0;
    end else if (adv) begin
      out_valid_reg  <= take;
      if (take) begin
        out_rs1_reg    <= dec_rs1;
        out_rs2_reg    <= dec_rs2;
        out_rd_reg     <= dec_rd;
        out_imm_reg    <= bus.in_instr[15:0];
        out_value_reg  <= bus.in_instr[25:0];
        out_alu_op_reg <= dec_alu_op;
        out_ctrl_reg   <= dec_ctrl;
      end
    end
  end

  assign bus.out_valid  = out_valid_reg;
  assign bus.out_rs1    = out_rs1_reg;
  assign bus.out_rs2    = out_rs2_reg;
  assign bus.out_rd     = out_rd_reg;
  assign bus.out_imm    = out_imm_reg;
  assign bus.out_value  = out_value_reg;
  assign bus.out_alu_op = out_alu_op_reg;
  assign bus.out_ctrl   = out_ctrl_reg;

`ifdef DLX_DECODE_PERF_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic        stall_ev, bubble_ev;
  logic [31:0] stall_cnt_reg, bubble_cnt_reg;

  assign stall_ev  = bus.in_valid & adv & hazard;
  assign bubble_ev = bus.flush | (adv & ~take);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg  <= '0;
      bubble_cnt_reg <= '0;
    end else begin
      if (stall_ev && (stall_cnt_reg != 32'hFFFF_FFFF))
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (bubble_ev && (bubble_cnt_reg != 32'hFFFF_FFFF))
        bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt  = stall_cnt_reg;
  assign bubble_cnt = bubble_cnt_reg;
`endif

endmodule

// File: tb/tb_dlx_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_dlx_decode_stage
// Self-checking bench for dlx_decode_stage. It runs these parts in order:
//   - a table of decode vectors
//   - hand sequences for load-use, backpressure, flush and mid-run reset
//     (plus the performance counters when DLX_DECODE_PERF_EN is defined)
//   - a randomized run checked against an instruction-level reference model
// -----------------------------------------------------------------------------
module tb_dlx_decode_stage;
  localparam int REG_AW   = 5;
  localparam int LOAD_LAT = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dlx_decode_stage_if #(.REG_AW(REG_AW)) bus ();

`ifdef DLX_DECODE_PERF_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif

  dlx_decode_stage #(.REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DLX_DECODE_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] value;
    logic [5:0]  alu;
    logic [15:0] ctrl;
  } bundle_t;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [5:0]  alu;
    logic [15:0] ctrl;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  localparam logic [31:0] LW_R5      = 32'h8C25_0000; // lw  r5,0(r1)
  localparam logic [31:0] ADD_R6_R5  = 32'h00A2_3020; // add r6,r5,r2
  localparam logic [31:0] LW_R0      = 32'h8C20_0000; // lw  r0,0(r1)
  localparam logic [31:0] ADD_R6_R0  = 32'h0002_3020; // add r6,r0,r2
  localparam logic [31:0] ADD_R3     = 32'h0022_1820; // add r3,r1,r2

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic fl, input logic ordy);
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.flush     = fl;
    bus.out_ready = ordy;
  endtask

  function automatic bundle_t actual_bundle();
    bundle_t b;
    b.rs1 = bus.out_rs1; b.rs2 = bus.out_rs2; b.rd = bus.out_rd;
    b.imm = bus.out_imm; b.value = bus.out_value;
    b.alu = bus.out_alu_op; b.ctrl = bus.out_ctrl;
    return b;
  endfunction

  // Reference decode that works from the numeric opcode value. It follows the
  // instruction-set description: named instructions plus opcode ranges.
  function automatic bundle_t ref_decode(input logic [31:0] i);
    bundle_t b;
    int op;
    logic reg_dst, alu_src, mem_wr, w_src, reg_wr, mem_sign;
    logic lh, link, bz, bnz, jmp, jr;
    logic [1:0] ds;
    op = int'(i[31:26]);
    b.rs1 = i[25:21]; b.rs2 = i[20:16]; b.rd = i[20:16];
    b.imm = i[15:0];  b.value = i[25:0]; b.alu = 6'd0;
    reg_wr = 1'b1; lh = 0; link = 0; bz = 0; bnz = 0; jmp = 0; jr = 0;
    alu_src  = (op >= 8);
    mem_wr   = (op >= 40 && op <= 47);
    w_src    = (op >= 32 && op <= 39);
    reg_dst  = (op <= 1);
    ds       = 2'(op % 4);
    mem_sign = !(op >= 36 && op <= 39);
    case (op)
      0: begin
        b.rd = i[15:11]; b.alu = i[5:0];
        if (i == 32'h15) reg_wr = 1'b0;
      end
      2:  begin jmp = 1; reg_wr = 0; end
      3:  begin jmp = 1; link = 1; b.rd = 5'd31; b.alu = 6'd32; end
      4:  begin bz = 1; reg_wr = 0; end
      5:  begin bnz = 1; reg_wr = 0; end
      15: begin lh = 1; b.alu = 6'd32; end
      18: begin jmp = 1; jr = 1; reg_wr = 0; end
      19: begin jmp = 1; jr = 1; link = 1; b.rd = 5'd31; b.alu = 6'd32; end
      default: begin
        if (op >= 8 && op <= 14)       b.alu = 6'(op + 24);
        else if (op >= 20 && op <= 23) b.alu = 6'(op - 16);
        else if (op >= 24 && op <= 31) b.alu = 6'(op + 16);
        else if (op >= 32 && op <= 39) b.alu = 6'd32;
        else if (op >= 40 && op <= 47) begin b.alu = 6'd32; reg_wr = 0; end
      end
    endcase
    b.ctrl = {reg_dst, alu_src, mem_wr, w_src, reg_wr, ds, mem_sign,
              lh, link, bz, bnz, jmp, jr, 2'b00};
    return b;
  endfunction

  function automatic logic [31:0] gen_instr();
    int ops [24] = '{0, 0, 0, 2, 3, 4, 5, 8, 9, 12, 15, 18, 19, 20, 24, 28,
                     32, 35, 36, 37, 40, 43, 63, 1};
    logic [5:0] op;
    logic [4:0] rs1, rs2, rd;
    logic [15:0] imm;
    op  = 6'(ops[$urandom_range(0, 23)]);
    rs1 = 5'($urandom_range(0, 3));
    rs2 = 5'($urandom_range(0, 3));
    rd  = 5'($urandom_range(0, 7));
    imm = 16'($urandom_range(0, 65535));
    if (op == 6'd0) begin
      if ($urandom_range(0, 9) == 0) return 32'h0000_0015;
      return {op, rs1, rs2, rd, 5'd0, 6'($urandom_range(0, 63))};
    end
    return {op, rs1, rs2, imm};
  endfunction

  // Random-run model state: register readiness measured in issue slots.
  int      ready_slot [32];
  int      slot;
  logic    exp_valid;
  bundle_t exp_b;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs = '{
      '{32'h0022_1820, 5'd3,  6'h20, 16'h8900},  // add r3,r1,r2
      '{32'h0C00_0040, 5'd31, 6'h20, 16'h0F48},  // jal 0x40
      '{32'h4BE0_0000, 5'd0,  6'h00, 16'h450C},  // jr r31
      '{32'h0000_0015, 5'd0,  6'h15, 16'h8100},  // nop
      '{32'h8C25_0000, 5'd5,  6'h20, 16'h5F00},  // lw r5,0(r1)
      '{32'h9044_0008, 5'd4,  6'h20, 16'h5800},  // lbu r4,8(r2)
      '{32'hAC22_0004, 5'd2,  6'h20, 16'h6700},  // sw 4(r1),r2
      '{32'h2027_0005, 5'd7,  6'h20, 16'h4900},  // addi r7,r1,5
      '{32'h3C08_1234, 5'd8,  6'h20, 16'h4F80},  // lhi r8,0x1234
      '{32'h5029_0003, 5'd9,  6'h04, 16'h4900},  // slli r9,r1,3
      '{32'h604A_0001, 5'd10, 6'h28, 16'h4900},  // slti r10,r2,1
      '{32'h1020_0008, 5'd0,  6'h00, 16'h0120},  // beqz r1
      '{32'h1420_0008, 5'd0,  6'h00, 16'h0310},  // bnez r1
      '{32'h0800_0100, 5'd0,  6'h00, 16'h0508},  // j 0x100
      '{32'h4C80_0000, 5'd31, 6'h20, 16'h4F4C},  // jalr r4
      '{32'hFC00_0000, 5'd0,  6'h00, 16'h4F00},  // undefined opcode
      '{32'h0400_0000, 5'd0,  6'h00, 16'h8B00},  // opcode 1
      '{32'h3043_00FF, 5'd3,  6'h24, 16'h4900}   // andi r3,r2,0xff
    };

    // ---------------- reset ----------------
    drive(0, 32'h0, 0, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_out_rd", 128'(bus.out_rd), 128'(0));
    check("rst_out_ctrl", 128'(bus.out_ctrl), 128'(0));
    check("rst_out_alu_op", 128'(bus.out_alu_op), 128'(0));
    check("rst_in_ready", 128'(bus.in_ready), 128'(1));
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 128'(bus.in_ready), 128'(1));

    // ---------------- decode table ----------------
    for (int k = 0; k < NV; k++) begin
      drive(1, vecs[k].instr, 0, 1);
      #1 check($sformatf("tbl%0d_in_ready", k), 128'(bus.in_ready), 128'(1));
      @(negedge clk);
      bus.in_valid = 1'b0;
      check($sformatf("tbl%0d_out_valid", k), 128'(bus.out_valid), 128'(1));
      check($sformatf("tbl%0d_rd", k), 128'(bus.out_rd), 128'(vecs[k].rd));
      check($sformatf("tbl%0d_alu_op", k), 128'(bus.out_alu_op), 128'(vecs[k].alu));
      check($sformatf("tbl%0d_ctrl", k), 128'(bus.out_ctrl), 128'(vecs[k].ctrl));
      @(negedge clk);
    end

    // ---------------- load-use ----------------
    drive(1, LW_R5, 0, 1);
    @(negedge clk);
    drive(1, ADD_R6_R5, 0, 1);
    #1 check("lu_stall_in_ready", 128'(bus.in_ready), 128'(0));
    check("lu_load_rd", 128'(bus.out_rd), 128'(5));
    @(negedge clk);
    check("lu_bubble_valid", 128'(bus.out_valid), 128'(0));
    #1 check("lu_resume_in_ready", 128'(bus.in_ready), 128'(1));
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("lu_add_valid", 128'(bus.out_valid), 128'(1));
    check("lu_add_rd", 128'(bus.out_rd), 128'(6));
    @(negedge clk);
    drive(1, LW_R0, 0, 1);
    @(negedge clk);
    drive(1, ADD_R6_R0, 0, 1);
    #1 check("lu_r0_no_stall", 128'(bus.in_ready), 128'(1));
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("lu_r0_add_valid", 128'(bus.out_valid), 128'(1));
    @(negedge clk);

    // ---------------- backpressure ----------------
    drive(1, LW_R5, 0, 1);
    @(negedge clk);
    drive(1, ADD_R6_R5, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #1 check($sformatf("bp%0d_in_ready", c), 128'(bus.in_ready), 128'(0));
      check($sformatf("bp%0d_valid", c), 128'(bus.out_valid), 128'(1));
      check($sformatf("bp%0d_bundle", c), 128'(actual_bundle()), 128'(ref_decode(LW_R5)));
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1 check("bp_sb_frozen", 128'(bus.in_ready), 128'(0));
    @(negedge clk);
    check("bp_bubble_valid", 128'(bus.out_valid), 128'(0));
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_add_valid", 128'(bus.out_valid), 128'(1));
    check("bp_add_rd", 128'(bus.out_rd), 128'(6));
    @(negedge clk);

    // ---------------- flush ----------------
    drive(1, LW_R5, 0, 1);
    @(negedge clk);
    drive(1, ADD_R6_R5, 1, 0);
    #1 check("fl_in_ready", 128'(bus.in_ready), 128'(1));
    @(negedge clk);
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    check("fl_out_valid", 128'(bus.out_valid), 128'(0));
    #1 check("fl_no_hazard", 128'(bus.in_ready), 128'(1));
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("fl_add_valid", 128'(bus.out_valid), 128'(1));
    check("fl_add_rd", 128'(bus.out_rd), 128'(6));
    @(negedge clk);

    // ---------------- mid-run asynchronous reset ----------------
    drive(1, ADD_R3, 0, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("async_rst_valid", 128'(bus.out_valid), 128'(0));
    check("async_rst_rd", 128'(bus.out_rd), 128'(0));
`ifdef DLX_DECODE_PERF_EN
    check("async_rst_stall_cnt", 128'(stall_cnt), 128'(0));
    check("async_rst_bubble_cnt", 128'(bubble_cnt), 128'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef DLX_DECODE_PERF_EN
    // ---------------- performance counters ----------------
    for (int r = 0; r < 2; r++) begin
      drive(1, LW_R5, 0, 1);
      @(negedge clk);
      drive(1, ADD_R6_R5, 0, 1);
      @(negedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    check("perf_stall_cnt", 128'(stall_cnt), 128'(2));
    check("perf_bubble_ge2", 128'(bubble_cnt >= 32'd2), 128'(1));
`endif

    // ---------------- randomized run against the reference model ----------------
    drive(0, 32'h0, 0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 32; r++) ready_slot[r] = 0;
    slot = 0;
    exp_valid = 1'b0;
    exp_b = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic v, ordy, adv, haz;
      logic [31:0] ins;
      int op, s1, s2;
      check($sformatf("rnd%0d_out_valid", cyc), 128'(bus.out_valid), 128'(exp_valid));
      if (exp_valid)
        check($sformatf("rnd%0d_bundle", cyc), 128'(actual_bundle()), 128'(exp_b));
      v    = ($urandom_range(0, 99) < 70);
      ordy = ($urandom_range(0, 99) < 75);
      ins  = gen_instr();
      drive(v, ins, 0, ordy);
      #1;
      op  = int'(ins[31:26]);
      s1  = int'(ins[25:21]);
      s2  = int'(ins[20:16]);
      adv = !exp_valid || ordy;
      haz = v && ((s1 != 0 && ready_slot[s1] > slot) ||
                  ((op == 0 || (op >= 40 && op <= 47)) && s2 != 0 && ready_slot[s2] > slot));
      check($sformatf("rnd%0d_in_ready", cyc), 128'(bus.in_ready), 128'(adv && !haz));
      if (adv) begin
        if (v && !haz) begin
          exp_valid = 1'b1;
          exp_b = ref_decode(ins);
          if (op >= 32 && op <= 39) ready_slot[s2] = slot + LOAD_LAT + 1;
        end else begin
          exp_valid = 1'b0;
        end
        slot++;
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
